// File: rtl/fp_acc_ctrl.sv
// Streaming FP accumulator controller driving a combinational fp_add_sub stage.
// Optional NaN-abort drain mode is enabled by defining FP_ACC_NAN_ABORT_EN.
`timescale 1ns/1ps
module fp_acc_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic [4:0]       out_flags,
  output logic [31:0]      add_opd1,
  output logic [31:0]      add_opd2,
  output logic             add_op,
  input  logic [31:0]      add_res,
  input  logic             add_ovf,
  input  logic             add_unf,
  input  logic             add_nan,
  input  logic             add_zero
);

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // a result is consumed on a rising edge where out_valid && out_ready.
`ifdef FP_ACC_NAN_ABORT_EN
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD, S_DRAIN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;
`endif

  state_t            state_q, state_d;
  logic [31:0]       acc_q;
  logic [CNT_W-1:0]  count_q, cnt_inc;
  logic              ovf_q, unf_q, nan_q, sat_q;
  logic              ovf_nxt, unf_nxt, nan_nxt, sat_nxt;
  logic              accept, cnt_full;

  assign accept   = in_valid && in_ready;
  assign cnt_full = &count_q;
  assign cnt_inc  = cnt_full ? count_q : count_q + CNT_W'(1);
  assign sat_nxt  = sat_q | cnt_full;
  assign ovf_nxt  = ovf_q | add_ovf;
  assign unf_nxt  = unf_q | add_unf;
  assign nan_nxt  = nan_q | add_nan;

  assign add_opd1 = acc_q;
  assign add_opd2 = in_data;
  assign add_op   = in_op;

`ifdef FP_ACC_NAN_ABORT_EN
  logic abort;
  assign abort = accept && !in_last && add_nan;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          if (in_last) state_d = S_HOLD;
`ifdef FP_ACC_NAN_ABORT_EN
          else if (abort) state_d = S_DRAIN;
`endif
          else state_d = S_ACCUM;
        end
      end
      S_HOLD: if (out_ready) state_d = S_IDLE;
`ifdef FP_ACC_NAN_ABORT_EN
      S_DRAIN: if (accept && in_last) state_d = S_HOLD;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q != S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      nan_q     <= 1'b0;
      sat_q     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_flags <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (accept && in_last) begin
            out_sum   <= add_res;
            out_count <= cnt_inc;
            out_flags <= {sat_nxt, ovf_nxt, unf_nxt, nan_nxt, add_zero};
            out_valid <= 1'b1;
            acc_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            nan_q     <= 1'b0;
            sat_q     <= 1'b0;
          end else if (accept) begin
            acc_q   <= add_res;
            count_q <= cnt_inc;
            ovf_q   <= ovf_nxt;
            unf_q   <= unf_nxt;
            nan_q   <= nan_nxt;
            sat_q   <= sat_nxt;
          end
        end
        S_HOLD: if (out_ready) out_valid <= 1'b0;
`ifdef FP_ACC_NAN_ABORT_EN
        // Beats after the NaN are dropped; the count reflects beats up to the abort.
        S_DRAIN: begin
          if (accept && in_last) begin
            out_sum   <= 32'h7FC0_0000;
            out_count <= count_q;
            out_flags <= {sat_q, ovf_q, unf_q, 1'b1, 1'b0};
            out_valid <= 1'b1;
            acc_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            nan_q     <= 1'b0;
            sat_q     <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_acc_ctrl.sv
// Bench for fp_acc_ctrl: real-arithmetic fp_add_sub stand-in plus a packet-level reference model.
`timescale 1ns/1ps
module tb_fp_acc_ctrl;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk, rst;
  logic             in_valid, in_ready, in_op, in_last;
  logic [31:0]      in_data;
  logic             out_valid, out_ready;
  logic [31:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  logic [4:0]       out_flags;
  logic [31:0]      add_opd1, add_opd2, add_res;
  logic             add_op, add_ovf, add_unf, add_nan, add_zero;

  typedef struct packed {
    logic [31:0] res;
    logic ovf, unf, nan, zero;
  } add_t;

  int checks = 0;
  int errors = 0;

  logic [31:0]      pkt_d[$];
  logic             pkt_o[$];
  logic [31:0]      exp_sum_q[$];
  logic [CNT_W-1:0] exp_cnt_q[$];
  logic [4:0]       exp_flag_q[$];

  function automatic real s2r(input logic [31:0] b);
    real m;
    int e;
    logic [63:0] inf_bits;
    e = int'({24'b0, b[30:23]});
    if (e == 255) begin
      inf_bits = {b[31], 11'h7FF, 52'h0};
      return $bitstoreal(inf_bits);
    end
    if (e == 0) m = real'(b[22:0]) * (2.0 ** (-149.0));
    else        m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
    return b[31] ? -m : m;
  endfunction

  // Adder stand-in: exact real arithmetic, truncated back to single, flush-to-zero.
  function automatic add_t fadd(input logic [31:0] a, input logic [31:0] b, input logic op);
    add_t r;
    real ra, rb, rs;
    logic [63:0] d;
    int se;
    logic a_inf, b_inf;
    r = '0;
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) || (b[30:23] == 8'hFF && b[22:0] != 23'h0)) begin
      r.res = 32'h7FC0_0000;
      r.nan = 1'b1;
      return r;
    end
    ra = s2r(a);
    rb = s2r(b);
    rs = op ? ra - rb : ra + rb;
    d  = $realtobits(rs);
    if (d[62:52] == 11'h7FF) begin
      if (d[51:0] != 52'h0) begin
        r.res = 32'h7FC0_0000;
        r.nan = 1'b1;
      end else begin
        r.res = {d[63], 8'hFF, 23'h0};
        r.ovf = !(a_inf || b_inf);
      end
    end else if (rs == 0.0) begin
      r.zero = 1'b1;
    end else begin
      se = int'({21'b0, d[62:52]}) - 896;
      if (se >= 255) begin
        r.res = {d[63], 8'hFF, 23'h0};
        r.ovf = 1'b1;
      end else if (se <= 0) begin
        r.res  = {d[63], 31'h0};
        r.unf  = 1'b1;
        r.zero = 1'b1;
      end else begin
        r.res = {d[63], se[7:0], d[51:29]};
      end
    end
    return r;
  endfunction

  add_t add_r;
  always_comb add_r = fadd(add_opd1, add_opd2, add_op);
  assign add_res  = add_r.res;
  assign add_ovf  = add_r.ovf;
  assign add_unf  = add_r.unf;
  assign add_nan  = add_r.nan;
  assign add_zero = add_r.zero;

  fp_acc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
    .out_flags(out_flags),
    .add_opd1(add_opd1), .add_opd2(add_opd2), .add_op(add_op), .add_res(add_res),
    .add_ovf(add_ovf), .add_unf(add_unf), .add_nan(add_nan), .add_zero(add_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference model: fold the whole packet through the adder from acc=0.
  task automatic model_packet();
    logic [31:0] acc = 32'h0;
    logic [31:0] sum = 32'h0;
    add_t r;
    int n = 0;
    logic ovf = 1'b0, unf = 1'b0, nan = 1'b0, zl = 1'b0, aborted = 1'b0;
    for (int i = 0; i < pkt_d.size(); i++) begin
      if (!aborted) begin
        r = fadd(acc, pkt_d[i], pkt_o[i]);
        n++;
        ovf |= r.ovf;
        unf |= r.unf;
        nan |= r.nan;
        acc = r.res;
        sum = r.res;
        zl  = r.zero;
`ifdef FP_ACC_NAN_ABORT_EN
        if (r.nan && i != pkt_d.size() - 1) aborted = 1'b1;
`endif
      end
    end
    if (aborted) begin
      sum = 32'h7FC0_0000;
      zl  = 1'b0;
    end
    exp_sum_q.push_back(sum);
    exp_cnt_q.push_back(CNT_W'(n > CNT_MAX ? CNT_MAX : n));
    exp_flag_q.push_back({(n > CNT_MAX), ovf, unf, nan, zl});
    pkt_d.delete();
    pkt_o.delete();
  endtask

  function automatic logic [31:0] rand_fp();
    int sel;
    sel = $urandom_range(0, 19);
    if (sel == 0) return 32'h7F7F_FFFF;
    if (sel == 1) return 32'h0000_0000;
    return {1'(($urandom_range(0, 1))), 8'($urandom_range(110, 144)), 23'($urandom)};
  endfunction

  // All driver tasks start and end at a falling edge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      in_op    = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic op, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_ready_timeout: in_ready=%b required 1", in_ready);
    end
    checks++;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    pkt_d.push_back(d);
    pkt_o.push_back(op);
    if (last) model_packet();
  endtask

  task automatic wait_result(input string name);
    int n = 0;
    logic [31:0] es;
    logic [CNT_W-1:0] ec;
    logic [4:0] ef;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid_timeout: out_valid=%b required 1", name, out_valid);
    end
    if (exp_sum_q.size() == 0) begin
      errors++;
      $display("FAIL %s_no_expected: queue empty, required one entry", name);
    end else begin
      es = exp_sum_q.pop_front();
      ec = exp_cnt_q.pop_front();
      ef = exp_flag_q.pop_front();
      checks++;
      if (out_sum !== es) begin
        errors++;
        $display("FAIL %s_sum: got %h required %h", name, out_sum, es);
      end
      checks++;
      if (out_count !== ec) begin
        errors++;
        $display("FAIL %s_count: got %0d required %0d", name, out_count, ec);
      end
      checks++;
      if (out_flags !== ef) begin
        errors++;
        $display("FAIL %s_flags: got %b required %b", name, out_flags, ef);
      end
    end
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pkt_d.delete();
    pkt_o.delete();
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_data = 32'h0; in_op = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 32'h0 || out_count !== '0 || out_flags !== 5'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b sum=%h count=%0d flags=%b required all 0",
               out_valid, out_sum, out_count, out_flags);
    end
    checks++;
    if (in_ready !== 1'b1 || add_opd1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b add_opd1=%h required 1/00000000", in_ready, add_opd1);
    end
    in_data = 32'hC0A0_1234;
    in_op   = 1'b1;
    #1;
    checks++;
    if (add_opd2 !== 32'hC0A0_1234 || add_op !== 1'b1) begin
      errors++;
      $display("FAIL passthrough: add_opd2=%h add_op=%b required c0a01234/1", add_opd2, add_op);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    send_beat(32'h3F80_0000, 1'b0, 1'b0);
    idle(2);
    send_beat(32'h4000_0000, 1'b0, 1'b0);
    idle(1);
    send_beat(32'h4040_0000, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: out_valid=%b required 1 one cycle after last beat", out_valid);
    end
    wait_result("basic");
    checks++;
    if (out_sum !== 32'h40C0_0000 || out_count !== 3'd3 || out_flags !== 5'b00000) begin
      errors++;
      $display("FAIL basic_const: sum=%h count=%0d flags=%b required 40c00000/3/00000",
               out_sum, out_count, out_flags);
    end
    release_result("basic");
  endtask

  task automatic test_single();
    send_beat(32'h3FC0_0000, 1'b1, 1'b1);
    wait_result("single");
    checks++;
    if (out_sum !== 32'hBFC0_0000 || out_count !== 3'd1) begin
      errors++;
      $display("FAIL single_const: sum=%h count=%0d required bfc00000/1", out_sum, out_count);
    end
    release_result("single");
  endtask

  task automatic test_ovf();
    send_beat(32'h7F7F_FFFF, 1'b0, 1'b0);
    send_beat(32'h7F7F_FFFF, 1'b0, 1'b0);
    send_beat(32'h3F80_0000, 1'b0, 1'b1);
    wait_result("ovf");
    checks++;
    if (out_flags !== 5'b01000 || out_sum !== 32'h7F80_0000) begin
      errors++;
      $display("FAIL ovf_sticky: flags=%b sum=%h required 01000/7f800000", out_flags, out_sum);
    end
    release_result("ovf");
  endtask

  task automatic test_zero();
    send_beat(32'h3F80_0000, 1'b0, 1'b0);
    send_beat(32'h3F80_0000, 1'b1, 1'b1);
    wait_result("zero");
    checks++;
    if (out_flags !== 5'b00001 || out_sum !== 32'h0) begin
      errors++;
      $display("FAIL zero_last: flags=%b sum=%h required 00001/00000000", out_flags, out_sum);
    end
    release_result("zero");
  endtask

  task automatic test_backpressure();
    send_beat(32'h4100_0000, 1'b0, 1'b0);
    send_beat(32'h3F00_0000, 1'b1, 1'b1);
    wait_result("bp");
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 32'h40F0_0000 ||
          out_count !== 3'd2 || out_flags !== 5'b00000) begin
        errors++;
        $display("FAIL bp_hold: in_ready=%b valid=%b sum=%h count=%0d flags=%b required 0/1/40f00000/2/00000",
                 in_ready, out_valid, out_sum, out_count, out_flags);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    idle(3);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_extra: out_valid=%b required 0 after held beats", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    send_beat(32'h7F7F_FFFF, 1'b0, 1'b0);
    send_beat(32'h7F7F_FFFF, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pkt_d.delete();
    pkt_o.delete();
    send_beat(32'h4000_0000, 1'b0, 1'b1);
    wait_result("rstmid");
    checks++;
    if (out_sum !== 32'h4000_0000 || out_count !== 3'd1 || out_flags !== 5'b00000) begin
      errors++;
      $display("FAIL rstmid_const: sum=%h count=%0d flags=%b required 40000000/1/00000",
               out_sum, out_count, out_flags);
    end
    release_result("rstmid");
  endtask

  task automatic test_nan();
    send_beat(32'h3F80_0000, 1'b0, 1'b0);
    send_beat(32'h7FC0_0000, 1'b0, 1'b0);
    send_beat(32'h4000_0000, 1'b0, 1'b0);
    send_beat(32'h4040_0000, 1'b0, 1'b1);
    wait_result("nan");
`ifdef FP_ACC_NAN_ABORT_EN
    checks++;
    if (out_sum !== 32'h7FC0_0000 || out_count !== 3'd2 || out_flags !== 5'b00010) begin
      errors++;
      $display("FAIL nan_abort: sum=%h count=%0d flags=%b required 7fc00000/2/00010",
               out_sum, out_count, out_flags);
    end
`else
    checks++;
    if (out_sum !== 32'h7FC0_0000 || out_count !== 3'd4 || out_flags !== 5'b00010) begin
      errors++;
      $display("FAIL nan_prop: sum=%h count=%0d flags=%b required 7fc00000/4/00010",
               out_sum, out_count, out_flags);
    end
`endif
    release_result("nan");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 7; i++) send_beat(32'h3F80_0000, 1'b0, (i == 6));
    wait_result("sat7");
    checks++;
    if (out_count !== 3'd7 || out_flags[4] !== 1'b0) begin
      errors++;
      $display("FAIL sat7: count=%0d cnt_sat=%b required 7/0", out_count, out_flags[4]);
    end
    release_result("sat7");
    for (int i = 0; i < 9; i++) send_beat(32'h3F80_0000, 1'b0, (i == 8));
    wait_result("sat9");
    checks++;
    if (out_count !== 3'd7 || out_flags[4] !== 1'b1 || out_sum !== 32'h4110_0000) begin
      errors++;
      $display("FAIL sat9: count=%0d cnt_sat=%b sum=%h required 7/1/41100000",
               out_count, out_flags[4], out_sum);
    end
    release_result("sat9");
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 3; i++) send_beat(rand_fp(), 1'($urandom_range(0, 1)), (i == 2));
      wait_result("b2b");
      release_result("b2b");
    end
  endtask

  task automatic test_random();
    int len;
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        send_beat(rand_fp(), 1'($urandom_range(0, 1)), (i == len - 1));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
      wait_result("random");
      release_result("random");
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = 32'h0; in_op = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_single();
    test_ovf();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_nan();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_acc_ctrl.md
Name: fp_acc_ctrl

Overview:
Streaming floating-point accumulator controller placed directly in front of the combinational fp_add_sub stage. It accepts a packet of IEEE-754 single-precision operands over a valid/ready handshake and drives fp_add_sub with the running sum and each new operand. It captures fp_add_sub's result and flags each beat, and emits one registered sum per packet with sticky exception flags and an element count.

Parameters:
CNT_W, 16, width of the per-packet element counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block accepts beat; beat transfers when in_valid && in_ready.
in_data  in  32  operand (IEEE-754 single).
in_op  in  1  0 = acc + in_data, 1 = acc - in_data.
in_last  in  1  marks the final beat of the packet.
out_valid  out  1  packet result valid.
out_ready  in  1  consumer accepts result.
out_sum  out  32  final accumulated value.
out_count  out  CNT_W  number of beats accepted in the packet (saturating).
out_flags  out  5  {cnt_sat, ovf_sticky, unf_sticky, nan_sticky, zero_last}.
add_opd1  out  32  to fp_add_sub opd1 = acc register.
add_opd2  out  32  to fp_add_sub opd2 = in_data (combinational pass-through).
add_op  out  1  to fp_add_sub op = in_op (combinational pass-through).
add_res  in  32  from fp_add_sub res.
add_ovf, add_unf, add_nan, add_zero  in  1 each  from fp_add_sub exp_overflow_flag, exp_underflow_flag, nan_flag, zero_flag.

Behaviour:
- fp_add_sub is combinational. add_res and flags are valid in the same cycle that add_opd* and add_op are driven. Per-beat accumulate latency is 1 cycle, so back-to-back beats are sustained.
- States: IDLE, ACCUM, HOLD (plus DRAIN, only when the optional feature is compiled in).
- Reset (rst=1 at an edge), from any state including mid-packet:
  - state=IDLE, acc=0x00000000, count=0, all sticky flags=0.
  - out_valid=0, out_sum=0, out_count=0, out_flags=0.
  - Any partial packet is discarded.
- in_ready = 1 in IDLE/ACCUM, 0 in HOLD. in_ready depends only on state, never on in_valid.
- Accepted beat, not last:
  - acc <= add_res.
  - count <= count+1, saturating at all-ones; cnt_sat is set when an increment is attempted at all-ones.
  - ovf/unf/nan sticky |= add_ovf/add_unf/add_nan.
  - IDLE -> ACCUM.
- Accepted beat with in_last=1 (from IDLE or ACCUM):
  - out_sum <= add_res.
  - out_count <= count+1 (saturating).
  - out_flags <= updated stickies with zero_last = add_zero.
  - out_valid <= 1; state -> HOLD.
  - acc, count and stickies cleared to 0 in the same edge.
- A single-beat packet (in_last on the first beat) yields out_sum = 0 ± in_data, out_count = 1.
- HOLD:
  - out_sum, out_count, out_flags and out_valid are held stable while out_ready=0.
  - When out_ready=1: out_valid <= 0, state -> IDLE. The next beat can be accepted on the following cycle, so there is no overlap of HOLD and input acceptance.
- No beat in IDLE/ACCUM: acc, count and flags unchanged. add_opd2 and add_op still follow in_data/in_op; the adder result is ignored.
- out_valid is never asserted combinationally. All outputs except in_ready and add_* are registers.

Optional Feature:
FP_ACC_NAN_ABORT_EN.
- Defined: an accepted non-last beat with add_nan=1 moves to DRAIN.
  - DRAIN keeps in_ready=1 and discards beats (no count or flag update) until a beat with in_last is accepted.
  - That beat then produces out_sum=0x7FC00000, nan_sticky=1, out_count = beats accepted before abort, zero_last=0; state -> HOLD.
  - If add_nan=1 on the last beat itself, the normal last-beat path applies.
- Undefined: no DRAIN state; NaN propagates through the adder normally and only sets nan_sticky.

Test Plan:
1. Reset, then packet 0x3F800000, 0x40000000, 0x40400000 (op=0, last on third) -> out_sum=0x40C00000, out_count=3, out_flags=00000, out_valid 1 cycle after third beat.
2. Single beat 0x3FC00000, op=1, last -> out_sum=0xBFC00000, out_count=1.
3. Packet 0x7F7FFFFF, 0x7F7FFFFF, 0x3F800000 (last) -> ovf_sticky=1 retained at output even though the final beat raised no overflow.
4. Result ready with out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 throughout, out_sum/flags stable; out_ready=1 -> out_valid drops next cycle, in_ready=1.
5. Two beats accepted, rst=1 one cycle, new packet 0x40000000 (last) -> out_sum=0x40000000, out_count=1, no stale flags.
6. With FP_ACC_NAN_ABORT_EN: beats 0x3F800000, 0x7FC00000, 0x40000000, 0x40400000 (last) -> out_sum=0x7FC00000, out_count=2, nan_sticky=1. Without it: same stimulus -> nan_sticky=1, out_count=4, out_sum = adder's NaN result.
